trail_collision_reader: RTL and testbench
=========================================

Name: trail_collision_reader

Overview:
- Reader counterpart to the trail writer.
- Once per game frame while in the play state, it reads the frame buffer word at the cell directly ahead of each bike and raises sticky collision flags for Blue and Red.
- Sits between the bike position/direction logic and the shared frame-buffer port; arbitrates for the port with a req/gnt handshake.
- Also detects out-of-bounds moves and head-on collisions.

Parameters:
- OFFSET, 20, cell offset added to X and Y before address computation.
- MAX_POS, 8'd223, largest legal X or Y after the move; greater is out of bounds.
- ROW_WORDS, 1280, address stride per Y cell (320*4).
- PROBE_WORDS, 2, consecutive words read per bike; any hit in the window counts.
- TRAIL_MASK, 16'h0F0F, bits that mark trail pixels in a read word.

Ports:
- Clk, in, 1, 50 MHz clock.
- Reset, in, 1, asynchronous active-high reset.
- frame_clk, in, 1, ~60 Hz frame indicator; synchronised internally, rising edge detected.
- Game_State, in, 3, play state is 3'b010.
- Blue_X, Blue_Y, Red_X, Red_Y, in, 8 each, current head cells.
- Blue_dir, Red_dir, in, 2 each: 00 up, 01 down, 10 left, 11 right.
- bus_req, out, 1, request for the frame-buffer port.
- bus_gnt, in, 1, port granted.
- rd_addr, out, 20, frame-buffer read address.
- rd_en, out, 1, read strobe.
- rd_data, in, 16, read data, valid exactly 1 cycle after rd_en.
- collision_blue, out, 1, sticky Blue crash flag.
- collision_red, out, 1, sticky Red crash flag.
- check_done, out, 1, one-cycle pulse at the end of each frame check.
- hit_addr, out, 20, first hit address (optional feature).

Behaviour:
- Reset: every output is 0; FSM is in IDLE.
- When Game_State != 3'b010: FSM forced to IDLE synchronously; collision flags, bus_req and hit_addr cleared.

Probe cell:
- Computed from the direction: up Y-1, down Y+1, left X-1, right X+1.
- Arithmetic is 9-bit signed. A result < 0 or > MAX_POS is out of bounds: that bike's flag is set and its reads are skipped.
- Address = (PX+OFFSET)*2 + ROW_WORDS*(PY+OFFSET), zero-extended to 20 bits.
- Word k of the window is read at address + k, for k = 0..PROBE_WORDS-1.

FSM states: IDLE, CALC, REQ, RD_B, CHK_B, RD_R, CHK_R, DONE.
- IDLE -> CALC on a synchronised frame_clk rising edge in the play state.
- CALC: latch both probe cells and addresses, and the out-of-bounds flags.
- REQ: assert bus_req; advance to RD_B when bus_gnt=1.
- bus_req is held from REQ through CHK_R.
- If bus_gnt drops mid-read: hold rd_en low and stall in the current state; resume the same word when bus_gnt returns.
- RD_B: rd_en=1, rd_addr = Blue address + k.
- CHK_B: (rd_data & TRAIL_MASK) != 0 sets collision_blue.
  - k < PROBE_WORDS-1: increment k and return to RD_B.
  - Otherwise: k=0 and go to RD_R.
- RD_R / CHK_R: same sequence for the Red address; the end of the window goes to DONE.
- A bike already out of bounds skips its read states.
- DONE: pulse check_done, drop bus_req, go to IDLE.
- Latency: edge to check_done is 3 + 4*PROBE_WORDS cycles with continuous grant; 11 cycles at the default.

Head-on and swap:
- If both probe cells are equal, both flags are set in CALC.
- If the Blue probe equals Red's current cell and the Red probe equals Blue's current cell (swap), both flags are set.

Flags and frame edges:
- Flags are sticky until play ends or Reset.
- A frame edge arriving while the FSM is not in IDLE is dropped, not queued.
- Reset asserted mid-read: immediate return to IDLE; bus_req and rd_en go low asynchronously.

Optional Feature:
- TRAIL_COLLISION_HITADDR_EN defined: hit_addr latches the rd_addr of the first word that set either flag, or the probe address for out-of-bounds/head-on hits. It holds until flags clear.
- Not defined: hit_addr is tied to 20'd0 and no register is inferred.

Test Plan:
- Play state, Blue (10,10) right, Red (50,50) up, rd_data always 0, bus_gnt=1, frame edge → check_done exactly 11 cycles after the edge, both flags 0. Reads at 2*31+1280*30=38462, 38463, then 2*70+1280*69=88460, 88461.
- Same setup, rd_data=16'h0100 on the second Blue word → collision_blue=1, collision_red=0; with the macro, hit_addr=38463.
- Blue X=0 moving left → collision_blue=1 with no Blue reads issued; Red reads still occur.
- Blue (30,30) right, Red (32,30) left (equal probe cells) → both flags set; check_done still pulses.
- bus_gnt low for 5 cycles after REQ, then high → no rd_en while low; check_done arrives 5 cycles later than the baseline.
- Game_State changed to 3'b000 during RD_R → flags clear, bus_req=0 next cycle, no check_done; a frame edge while busy produces no second check.

Source files
------------

// File: rtl/trail_collision_reader.sv
// rtl/trail_collision_reader.sv - per-frame look-ahead trail reader raising sticky Blue/Red crash flags
// Optional: define TRAIL_COLLISION_HITADDR_EN to latch the first hit address on hit_addr.
module trail_collision_reader #(
  parameter int          OFFSET      = 20,
  parameter logic [7:0]  MAX_POS     = 8'd223,
  parameter int          ROW_WORDS   = 1280,
  parameter int          PROBE_WORDS = 2,
  parameter logic [15:0] TRAIL_MASK  = 16'h0F0F
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [2:0]  Game_State,
  input  logic [7:0]  Blue_X,
  input  logic [7:0]  Blue_Y,
  input  logic [7:0]  Red_X,
  input  logic [7:0]  Red_Y,
  input  logic [1:0]  Blue_dir,
  input  logic [1:0]  Red_dir,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [19:0] rd_addr,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        collision_blue,
  output logic        collision_red,
  output logic        check_done,
  output logic [19:0] hit_addr
);

  localparam logic [2:0] PLAY = 3'b010;
  localparam int KW = (PROBE_WORDS > 1) ? $clog2(PROBE_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PROBE_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_RD_B  = 3'd3;
  localparam logic [2:0] S_CHK_B = 3'd4;
  localparam logic [2:0] S_RD_R  = 3'd5;
  localparam logic [2:0] S_CHK_R = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  function automatic logic [17:0] probe(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] dir);
    logic [8:0] px;
    logic [8:0] py;
    px = {1'b0, x};
    py = {1'b0, y};
    case (dir)
      2'b00:   py = py - 9'd1;
      2'b01:   py = py + 9'd1;
      2'b10:   px = px - 9'd1;
      default: px = px + 9'd1;
    endcase
    return {px, py};
  endfunction

  // Bit 8 set means the signed result went negative.
  function automatic logic off_board(input logic [8:0] v);
    return v[8] || (v[7:0] > MAX_POS);
  endfunction

  function automatic logic [19:0] addr_of(input logic [8:0] px, input logic [8:0] py);
    logic [31:0] a;
    a = (32'(px) + 32'(OFFSET)) * 32'd2 + 32'(ROW_WORDS) * (32'(py) + 32'(OFFSET));
    return a[19:0];
  endfunction

  logic [2:0]    st;
  logic [KW-1:0] k;
  logic [2:0]    fsync;
  logic [19:0]   addr_b, addr_r;
  logic          oob_b, oob_r;
  logic [8:0]    bpx, bpy, rpx, rpy;
  logic          b_oob, r_oob, head_on, rise, data_hit, play;

  assign {bpx, bpy} = probe(Blue_X, Blue_Y, Blue_dir);
  assign {rpx, rpy} = probe(Red_X, Red_Y, Red_dir);
  assign b_oob    = off_board(bpx) || off_board(bpy);
  assign r_oob    = off_board(rpx) || off_board(rpy);
  assign head_on  = (bpx == rpx && bpy == rpy) ||
                    (bpx == {1'b0, Red_X} && bpy == {1'b0, Red_Y} &&
                     rpx == {1'b0, Blue_X} && rpy == {1'b0, Blue_Y});
  assign rise     = fsync[1] & ~fsync[2];
  assign data_hit = |(rd_data & TRAIL_MASK);
  assign play     = (Game_State == PLAY);

  assign bus_req    = (st == S_REQ) || (st == S_RD_B) || (st == S_CHK_B) ||
                      (st == S_RD_R) || (st == S_CHK_R);
  assign rd_en      = ((st == S_RD_B) || (st == S_RD_R)) && bus_gnt;
  assign check_done = (st == S_DONE);
  assign rd_addr    = (st == S_RD_B) ? addr_b + 20'(k) :
                      (st == S_RD_R) ? addr_r + 20'(k) : 20'd0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st             <= S_IDLE;
      k              <= '0;
      fsync          <= '0;
      addr_b         <= '0;
      addr_r         <= '0;
      oob_b          <= 1'b0;
      oob_r          <= 1'b0;
      collision_blue <= 1'b0;
      collision_red  <= 1'b0;
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      if (!play) begin
        st             <= S_IDLE;
        k              <= '0;
        collision_blue <= 1'b0;
        collision_red  <= 1'b0;
      end else begin
        case (st)
          S_IDLE: if (rise) st <= S_CALC;
          S_CALC: begin
            addr_b <= addr_of(bpx, bpy);
            addr_r <= addr_of(rpx, rpy);
            oob_b  <= b_oob;
            oob_r  <= r_oob;
            if (b_oob || head_on) collision_blue <= 1'b1;
            if (r_oob || head_on) collision_red  <= 1'b1;
            k  <= '0;
            st <= S_REQ;
          end
          S_REQ: if (bus_gnt) st <= oob_b ? (oob_r ? S_DONE : S_RD_R) : S_RD_B;
          S_RD_B: if (bus_gnt) st <= S_CHK_B;
          S_CHK_B: begin
            if (data_hit) collision_blue <= 1'b1;
            if (k != K_LAST) begin
              k  <= k + KW'(1);
              st <= S_RD_B;
            end else begin
              k  <= '0;
              st <= oob_r ? S_DONE : S_RD_R;
            end
          end
          S_RD_R: if (bus_gnt) st <= S_CHK_R;
          S_CHK_R: begin
            if (data_hit) collision_red <= 1'b1;
            if (k != K_LAST) begin
              k  <= k + KW'(1);
              st <= S_RD_R;
            end else begin
              k  <= '0;
              st <= S_DONE;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TRAIL_COLLISION_HITADDR_EN
  logic [19:0] hit_q;

  // Only the first event after the flags were clear may load the register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q <= '0;
    end else if (!play) begin
      hit_q <= '0;
    end else if (!collision_blue && !collision_red) begin
      if (st == S_CALC) begin
        if (b_oob || head_on) hit_q <= addr_of(bpx, bpy);
        else if (r_oob)       hit_q <= addr_of(rpx, rpy);
      end else if (st == S_CHK_B && data_hit) begin
        hit_q <= addr_b + 20'(k);
      end else if (st == S_CHK_R && data_hit) begin
        hit_q <= addr_r + 20'(k);
      end
    end
  end

  assign hit_addr = hit_q;
`else
  assign hit_addr = 20'd0;
`endif

endmodule

// File: tb/tb_trail_collision_reader.sv
// tb/tb_trail_collision_reader.sv - directed plus randomized check of trail_collision_reader against a frame-level model
module tb_trail_collision_reader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [2:0]  Game_State = 3'b000;
  logic [7:0]  Blue_X = 8'd0, Blue_Y = 8'd0, Red_X = 8'd0, Red_Y = 8'd0;
  logic [1:0]  Blue_dir = 2'd0, Red_dir = 2'd0;
  logic        bus_gnt = 1'b1;
  logic [15:0] rd_data = 16'h0;
  logic        bus_req, rd_en, collision_blue, collision_red, check_done;
  logic [19:0] rd_addr, hit_addr;

  trail_collision_reader dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .Blue_dir(Blue_dir), .Red_dir(Red_dir), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .collision_blue(collision_blue), .collision_red(collision_red),
    .check_done(check_done), .hit_addr(hit_addr)
  );

  always #10 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  logic [15:0] mem [int];
  int reads[$];
  int exp_reads[$];
  int exp_lat;
  int m_b = 0, m_r = 0, m_hit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hit(input string tag);
`ifdef TRAIL_COLLISION_HITADDR_EN
    chk(tag, 32'(hit_addr), m_hit);
`else
    chk(tag, 32'(hit_addr), 0);
`endif
  endtask

  function automatic int word_at(input int a);
    return mem.exists(a) ? int'(mem[a]) : 0;
  endfunction

  // Frame-buffer response: data for the address strobed in the previous cycle.
  initial begin
    logic en;
    int   a;
    forever begin
      @(negedge Clk);
      en = rd_en;
      a  = int'(rd_addr);
      @(posedge Clk);
      #1;
      rd_data = en ? 16'(word_at(a)) : 16'h0;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (rd_en) reads.push_back(int'(rd_addr));
  end

  function automatic void probe(input int x, input int y, input int d,
                                output int px, output int py);
    px = x;
    py = y;
    case (d)
      0:       py = py - 1;
      1:       py = py + 1;
      2:       px = px - 1;
      default: px = px + 1;
    endcase
  endfunction

  // Out-of-range coordinates wrap as 9-bit values, then the sum is kept to 20 bits.
  function automatic int addr_of(input int px, input int py);
    return (((px & 511) + 20) * 2 + 1280 * ((py & 511) + 20)) & 32'hFFFFF;
  endfunction

  function automatic bit off(input int px, input int py);
    return px < 0 || px > 223 || py < 0 || py > 223;
  endfunction

  task automatic model_frame(input int stall);
    int bx, by, rx, ry, bpx, bpy, rpx, rpy, ab, ar;
    bit bo, ro, ho, first;
    bx = int'(Blue_X); by = int'(Blue_Y); rx = int'(Red_X); ry = int'(Red_Y);
    probe(bx, by, int'(Blue_dir), bpx, bpy);
    probe(rx, ry, int'(Red_dir), rpx, rpy);
    ab = addr_of(bpx, bpy);
    ar = addr_of(rpx, rpy);
    bo = off(bpx, bpy);
    ro = off(rpx, rpy);
    ho = (bpx == rpx && bpy == rpy) ||
         (bpx == rx && bpy == ry && rpx == bx && rpy == by);
    first = (m_b == 0 && m_r == 0);
    exp_reads.delete();
    if (bo || ho) m_b = 1;
    if (ro || ho) m_r = 1;
    if (first && (bo || ho || ro)) begin
      m_hit = (bo || ho) ? ab : ar;
      first = 0;
    end
    if (!bo) for (int i = 0; i < 2; i++) begin
      exp_reads.push_back(ab + i);
      if ((word_at(ab + i) & 16'h0F0F) != 0) begin
        if (first) begin m_hit = ab + i; first = 0; end
        m_b = 1;
      end
    end
    if (!ro) for (int i = 0; i < 2; i++) begin
      exp_reads.push_back(ar + i);
      if ((word_at(ar + i) & 16'h0F0F) != 0) begin
        if (first) begin m_hit = ar + i; first = 0; end
        m_r = 1;
      end
    end
    // Two synchroniser stages, then CALC + REQ + DONE and two cycles per word read.
    exp_lat = 2 + 3 + 2 * exp_reads.size() + stall;
  endtask

  task automatic run_frame(input string tag, input int stall);
    int n, held, viol;
    bit done;
    model_frame(stall);
    reads.delete();
    @(negedge Clk);
    bus_gnt = (stall == 0);
    frame_clk = 1'b1;
    n = 0; held = 0; viol = 0; done = 0;
    while (!done && n < 200) begin
      @(negedge Clk);
      n++;
      if (!bus_gnt) begin
        if (rd_en) viol++;
        if (bus_req) begin
          held++;
          if (held > stall) bus_gnt = 1'b1;
        end
      end
      if (check_done) done = 1;
    end
    bus_gnt = 1'b1;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_rd_en_no_gnt"}, viol, 0);
    @(negedge Clk);
    frame_clk = 1'b0;
    chk({tag, "_done_pulse"}, 32'(check_done), 0);
    chk({tag, "_nreads"}, reads.size(), exp_reads.size());
    for (int i = 0; i < reads.size() && i < exp_reads.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), reads[i], exp_reads[i]);
    chk({tag, "_blue"}, 32'(collision_blue), m_b);
    chk({tag, "_red"}, 32'(collision_red), m_r);
    chk_hit({tag, "_hit"});
    repeat (3) @(negedge Clk);
  endtask

  task automatic leave_play();
    @(negedge Clk);
    Game_State = 3'b000;
    @(negedge Clk);
    m_b = 0; m_r = 0; m_hit = 0;
    chk("leave_blue", 32'(collision_blue), 0);
    chk("leave_red", 32'(collision_red), 0);
    Game_State = 3'b010;
  endtask

  task automatic set_bikes(input int bx, input int by, input int bd,
                           input int rx, input int ry, input int rdir);
    Blue_X = 8'(bx); Blue_Y = 8'(by); Blue_dir = 2'(bd);
    Red_X = 8'(rx); Red_Y = 8'(ry); Red_dir = 2'(rdir);
  endtask

  initial begin
    int n, cnt, bpx, bpy, rpx, rpy, st;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_done", 32'(check_done), 0);
    chk("rst_blue", 32'(collision_blue), 0);
    chk("rst_red", 32'(collision_red), 0);
    chk("rst_hit", 32'(hit_addr), 0);
    Reset = 1'b0;
    Game_State = 3'b010;
    repeat (3) @(negedge Clk);

    // Baseline: reads at 38462/38463 then 88460/88461, 11 cycles after the synchronised edge
    set_bikes(10, 10, 3, 50, 50, 0);
    run_frame("base", 0);
    chk("base_first_addr", exp_reads.size() > 0 ? exp_reads[0] : -1, 38462);

    // Trail hit on the second Blue word
    mem[38463] = 16'h0100;
    run_frame("bhit", 0);
    chk("bhit_model_hit", m_hit, 38463);
    leave_play();
    mem.delete();

    // Blue off the left edge: no Blue reads
    set_bikes(0, 40, 2, 50, 50, 0);
    run_frame("oob", 0);
    leave_play();

    // Equal probe cells
    set_bikes(30, 30, 3, 32, 30, 2);
    run_frame("headon", 0);
    leave_play();

    // Grant withheld for 5 cycles after REQ
    set_bikes(10, 10, 3, 50, 50, 0);
    run_frame("stall", 5);

    // Play ends during RD_R
    mem[38462] = 16'h000F;
    model_frame(0);
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!(rd_en && rd_addr == 20'd88460) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_reached_rd_r", 32'(n < 100), 1);
    chk("abort_blue_before", 32'(collision_blue), 1);
    Game_State = 3'b000;
    @(negedge Clk);
    m_b = 0; m_r = 0; m_hit = 0;
    chk("abort_bus_req", 32'(bus_req), 0);
    chk("abort_blue", 32'(collision_blue), 0);
    chk_hit("abort_hit");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (check_done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    frame_clk = 1'b0;
    mem.delete();
    repeat (3) @(negedge Clk);
    Game_State = 3'b010;
    repeat (2) @(negedge Clk);

    // A second edge while busy is dropped
    @(negedge Clk);
    frame_clk = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (i == 4) frame_clk = 1'b0;
      if (i == 7) frame_clk = 1'b1;
      if (check_done) cnt++;
    end
    chk("busy_edge_done_count", cnt, 1);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset mid-read releases the bus at once
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!rd_en && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("rst_mid_reached_read", 32'(n < 100), 1);
    #3;
    Reset = 1'b1;
    #1;
    chk("rst_mid_bus_req", 32'(bus_req), 0);
    chk("rst_mid_rd_en", 32'(rd_en), 0);
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    m_b = 0; m_r = 0; m_hit = 0;
    repeat (4) @(negedge Clk);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) leave_play();
      if ($urandom_range(0, 3) == 0) Blue_X = ($urandom_range(0, 1) == 1) ? 8'd223 : 8'd0;
      else Blue_X = 8'($urandom_range(0, 223));
      Blue_Y = 8'($urandom_range(0, 223));
      Blue_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0 && Blue_X <= 8'd221) begin
        Red_X = Blue_X + 8'd2; Red_Y = Blue_Y; Blue_dir = 2'd3; Red_dir = 2'd2;
      end else begin
        Red_X = 8'($urandom_range(0, 223));
        Red_Y = ($urandom_range(0, 3) == 0) ? 8'd223 : 8'($urandom_range(0, 223));
        Red_dir = 2'($urandom_range(0, 3));
      end
      mem.delete();
      if ($urandom_range(0, 1) == 1) begin
        probe(int'(Blue_X), int'(Blue_Y), int'(Blue_dir), bpx, bpy);
        probe(int'(Red_X), int'(Red_Y), int'(Red_dir), rpx, rpy);
        if ($urandom_range(0, 1) == 1)
          mem[addr_of(bpx, bpy) + int'($urandom_range(0, 1))] = 16'($urandom_range(0, 65535));
        else
          mem[addr_of(rpx, rpy) + int'($urandom_range(0, 1))] = 16'($urandom_range(0, 65535));
      end
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_frame($sformatf("rnd%0d", it), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
